// File: rtl/gcd_seq_unit.sv
// ---------------------------------------------------------------------------
// gcd_seq_unit
// Sequential subtract-and-compare Euclid GCD engine. One subtraction per
// cycle, valid/ready handshakes on both the operand and the result side.
// Besides the GCD it reports the magnitude relation of the original operands
// and how many subtraction steps were taken, in a saturating counter.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clear      synchronous soft abort, returns the FSM to IDLE
//   in_valid   operand pair valid
//   in_ready   block can accept operands (registered, IDLE only)
//   in_a/in_b  unsigned operands, WIDTH bits
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts the result
//   out_gcd    gcd(A,B), WIDTH bits
//   out_iter   subtraction steps, ITER_W bits, saturating
//   out_zero   both operands were zero
//   out_lt/gt/eq  original A <, >, == B
//   busy       FSM in CALC
// ---------------------------------------------------------------------------
module gcd_seq_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ITER_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_gcd,
  output logic [ITER_W-1:0] out_iter,
  output logic              out_zero,
  output logic              out_lt,
  output logic              out_gt,
  output logic              out_eq,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_gcd;
  logic [ITER_W-1:0]   r_iter;
  logic                r_zero;
  logic                r_lt;
  logic                r_gt;
  logic                r_eq;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;

  // Handshake qualifiers and operand classification at the accept edge
  logic                w_accept;
  logic                w_consume;
  logic                w_in_any_zero;
  logic                w_in_both_zero;
  logic                w_in_lt;
  logic                w_in_gt;
  logic                w_in_eq;

  // Working-operand comparison and saturating step count
  logic                w_work_eq;
  logic                w_work_gt;
  logic                w_iter_sat;
  logic [ITER_W-1:0]   w_iter_next;

  assign w_accept       = in_valid && r_in_ready && (r_state == S_IDLE);
  assign w_consume      = r_out_valid && out_ready;
  assign w_in_any_zero  = (in_a == '0) || (in_b == '0);
  assign w_in_both_zero = (in_a == '0) && (in_b == '0);
  assign w_in_lt        = (in_a <  in_b);
  assign w_in_gt        = (in_a >  in_b);
  assign w_in_eq        = (in_a == in_b);

  assign w_work_eq   = (r_a == r_b);
  assign w_work_gt   = (r_a >  r_b);
  assign w_iter_sat  = &r_iter;
  // Counter holds at all-ones instead of wrapping
  assign w_iter_next = w_iter_sat ? r_iter : r_iter + ITER_W'(1);

  // Control FSM with registered status/result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_gcd       <= '0;
      r_iter      <= '0;
      r_zero      <= 1'b0;
      r_lt        <= 1'b0;
      r_gt        <= 1'b0;
      r_eq        <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (clear) begin
      // Abort wins over an accept on the same edge; result values are kept,
      // only the handshake state is discarded.
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_a        <= in_a;
            r_b        <= in_b;
            r_iter     <= '0;
            r_lt       <= w_in_lt;
            r_gt       <= w_in_gt;
            r_eq       <= w_in_eq;
            r_in_ready <= 1'b0;
            if (w_in_any_zero) begin
              // gcd(x,0) = x, so the OR of the operands is the answer
              r_gcd       <= in_a | in_b;
              r_zero      <= w_in_both_zero;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_zero  <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end
          end
        end

        S_CALC: begin
          if (w_work_eq) begin
            r_gcd       <= r_a;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_work_gt) begin
            r_a    <= r_a - r_b;
            r_iter <= w_iter_next;
          end else begin
            r_b    <= r_b - r_a;
            r_iter <= w_iter_next;
          end
        end

        S_DONE: begin
          if (w_consume) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_gcd   = r_gcd;
  assign out_iter  = r_iter;
  assign out_zero  = r_zero;
  assign out_lt    = r_lt;
  assign out_gt    = r_gt;
  assign out_eq    = r_eq;

endmodule

// File: tb/tb_gcd_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_gcd_seq_unit
// Directed bench for gcd_seq_unit. u0 is the default 32/16 configuration,
// u1 is WIDTH=8 and u2 is ITER_W=4 for the width and saturation corners.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_gcd_seq_unit;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  // u0: WIDTH=32, ITER_W=16
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_gcd;
  logic [15:0] out_iter;
  logic        out_zero, out_lt, out_gt, out_eq, busy;

  // u1: WIDTH=8, ITER_W=16
  logic        u1_in_valid, u1_in_ready, u1_out_valid, u1_out_ready;
  logic [7:0]  u1_in_a, u1_in_b, u1_out_gcd;
  logic [15:0] u1_out_iter;
  logic        u1_out_zero, u1_out_lt, u1_out_gt, u1_out_eq, u1_busy;

  // u2: WIDTH=32, ITER_W=4
  logic        u2_in_valid, u2_in_ready, u2_out_valid, u2_out_ready;
  logic [31:0] u2_in_a, u2_in_b, u2_out_gcd;
  logic [3:0]  u2_out_iter;
  logic        u2_out_zero, u2_out_lt, u2_out_gt, u2_out_eq, u2_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gcd_seq_unit #(.WIDTH(32), .ITER_W(16)) u0 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd),
    .out_iter(out_iter), .out_zero(out_zero), .out_lt(out_lt),
    .out_gt(out_gt), .out_eq(out_eq), .busy(busy)
  );

  gcd_seq_unit #(.WIDTH(8), .ITER_W(16)) u1 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(u1_in_valid), .in_ready(u1_in_ready), .in_a(u1_in_a), .in_b(u1_in_b),
    .out_valid(u1_out_valid), .out_ready(u1_out_ready), .out_gcd(u1_out_gcd),
    .out_iter(u1_out_iter), .out_zero(u1_out_zero), .out_lt(u1_out_lt),
    .out_gt(u1_out_gt), .out_eq(u1_out_eq), .busy(u1_busy)
  );

  gcd_seq_unit #(.WIDTH(32), .ITER_W(4)) u2 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(u2_in_valid), .in_ready(u2_in_ready), .in_a(u2_in_a), .in_b(u2_in_b),
    .out_valid(u2_out_valid), .out_ready(u2_out_ready), .out_gcd(u2_out_gcd),
    .out_iter(u2_out_iter), .out_zero(u2_out_zero), .out_lt(u2_out_lt),
    .out_gt(u2_out_gt), .out_eq(u2_out_eq), .busy(u2_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on u0 with out_ready high. exp_lat counts edges after
  // the accept edge until out_valid is seen (0 = valid right after accept).
  task automatic run_pair(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int exp_gcd, input int exp_iter, input int exp_lat,
                          input logic e_lt, input logic e_gt, input logic e_eq,
                          input logic e_zero);
    int lat;
    out_ready = 1'b1;
    chk({tag, "_in_ready_pre"}, 64'(in_ready), 64'd1);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 2000) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_gcd"}, 64'(out_gcd), 64'(exp_gcd));
    chk({tag, "_iter"}, 64'(out_iter), 64'(exp_iter));
    chk({tag, "_lt"}, 64'(out_lt), 64'(e_lt));
    chk({tag, "_gt"}, 64'(out_gt), 64'(e_gt));
    chk({tag, "_eq"}, 64'(out_eq), 64'(e_eq));
    chk({tag, "_zero"}, 64'(out_zero), 64'(e_zero));
    tick();
    chk({tag, "_in_ready_post"}, 64'(in_ready), 64'd1);
    chk({tag, "_valid_post"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int saw;
    int k;
    int r;
    int cyc;
    logic pend;
    logic [31:0] pa [3];
    logic [31:0] pb [3];
    int eg [3];
    int ei [3];

    rst = 1'b1;
    clear = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    u1_in_valid = 1'b0; u1_out_ready = 1'b1; u1_in_a = '0; u1_in_b = '0;
    u2_in_valid = 1'b0; u2_out_ready = 1'b1; u2_in_a = '0; u2_in_b = '0;

    // Reset state
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gcd", 64'(out_gcd), 64'd0);
    chk("rst_iter", 64'(out_iter), 64'd0);
    tick();
    tick();
    chk("rst_hold_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    tick();
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_busy", 64'(busy), 64'd0);

    // Basic and zero-operand transactions
    run_pair("p12_8", 32'd12, 32'd8, 4, 2, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    run_pair("p0_0", 32'd0, 32'd0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_pair("p0_7", 32'd0, 32'd7, 7, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_pair("p9_0", 32'd9, 32'd0, 9, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_pair("p12_12", 32'd12, 32'd12, 12, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure: (21,14) -> 7 after 2 steps, held while out_ready low
    out_ready = 1'b0;
    in_a = 32'd21; in_b = 32'd14; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_in_ready_busy", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 2000) begin
      tick();
      lat++;
    end
    chk("bp_latency", 64'(lat), 64'd3);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_gcd", 64'(out_gcd), 64'd7);
      chk("bp_hold_eq", 64'(out_eq), 64'd0);
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_consume_in_ready", 64'(in_ready), 64'd1);
    chk("bp_consume_valid", 64'(out_valid), 64'd0);
    chk("bp_retained_gcd", 64'(out_gcd), 64'd7);

    // Clear 5 cycles into CALC on (1000,3)
    in_a = 32'd1000; in_b = 32'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("clr_busy_before", 64'(busy), 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_in_ready", 64'(in_ready), 64'd1);
    chk("clr_valid", 64'(out_valid), 64'd0);
    saw = 0;
    repeat (20) begin
      tick();
      if (out_valid || busy) saw = 1;
    end
    chk("clr_no_result", 64'(saw), 64'd0);

    // Clear coinciding with an accept drops the operands
    in_a = 32'd5; in_b = 32'd10; in_valid = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clracc_busy", 64'(busy), 64'd0);
    chk("clracc_valid", 64'(out_valid), 64'd0);
    chk("clracc_in_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of CALC
    in_a = 32'd1000; in_b = 32'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("rstc_gcd", 64'(out_gcd), 64'd0);
    chk("rstc_iter", 64'(out_iter), 64'd0);
    chk("rstc_gt", 64'(out_gt), 64'd0);
    chk("rstc_busy", 64'(busy), 64'd0);
    chk("rstc_in_ready", 64'(in_ready), 64'd0);
    chk("rstc_valid", 64'(out_valid), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rstc_rel_in_ready", 64'(in_ready), 64'd1);
    run_pair("p6_6", 32'd6, 32'd6, 6, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back with in_valid held high
    pa[0] = 32'd48; pb[0] = 32'd18; eg[0] = 6; ei[0] = 4;
    pa[1] = 32'd17; pb[1] = 32'd5;  eg[1] = 1; ei[1] = 6;
    pa[2] = 32'd7;  pb[2] = 32'd7;  eg[2] = 7; ei[2] = 0;
    k = 0; r = 0; cyc = 0;
    out_ready = 1'b1;
    in_a = pa[0]; in_b = pb[0]; in_valid = 1'b1;
    while (r < 3 && cyc < 1000) begin
      pend = in_valid && in_ready;
      if (out_valid) begin
        chk("b2b_gcd", 64'(out_gcd), 64'(eg[r]));
        chk("b2b_iter", 64'(out_iter), 64'(ei[r]));
        r++;
      end
      tick();
      cyc++;
      if (pend) begin
        k++;
        if (k < 3) begin
          in_a = pa[k];
          in_b = pb[k];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("b2b_results", 64'(r), 64'd3);
    chk("b2b_accepts", 64'(k), 64'd3);
    saw = 0;
    repeat (10) begin
      if (out_valid) saw++;
      tick();
    end
    chk("b2b_no_duplicate", 64'(saw), 64'd0);

    // WIDTH=8: (255,1) -> gcd 1 after 254 steps
    chk("w8_in_ready", 64'(u1_in_ready), 64'd1);
    u1_in_a = 8'd255; u1_in_b = 8'd1; u1_in_valid = 1'b1;
    tick();
    u1_in_valid = 1'b0;
    lat = 0;
    while (!u1_out_valid && lat < 2000) begin
      tick();
      lat++;
    end
    chk("w8_latency", 64'(lat), 64'd255);
    chk("w8_gcd", 64'(u1_out_gcd), 64'd1);
    chk("w8_iter", 64'(u1_out_iter), 64'd254);
    chk("w8_gt", 64'(u1_out_gt), 64'd1);
    tick();

    // ITER_W=4: (100,1) -> gcd 1, counter saturates at 15
    chk("sat_in_ready", 64'(u2_in_ready), 64'd1);
    u2_in_a = 32'd100; u2_in_b = 32'd1; u2_in_valid = 1'b1;
    tick();
    u2_in_valid = 1'b0;
    lat = 0;
    while (!u2_out_valid && lat < 2000) begin
      tick();
      lat++;
    end
    chk("sat_latency", 64'(lat), 64'd100);
    chk("sat_gcd", 64'(u2_out_gcd), 64'd1);
    chk("sat_iter", 64'(u2_out_iter), 64'd15);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
